// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_if
//  Brief    : Request/response bundle between the register bank and div_unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            flush;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic [4:0]      wb_addr;
    logic            wb_enable;

    modport master (
        output start, op, rs1_data, rs2_data, rd_addr, flush,
        input  busy, result, result_valid, wb_addr, wb_enable
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_addr, flush,
        output busy, result, result_valid, wb_addr, wb_enable
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Brief    : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    div_unit_if.slave   bus
);
    localparam int          OP_UNS_BIT = 0;
    localparam int          OP_REM_BIT = 1;
    localparam logic [5:0]  LAST_ITER  = 6'd31;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q,   cnt_d;
    logic [1:0]      op_q,    op_d;
    logic [4:0]      addr_q,  addr_d;
    logic [XLEN-1:0] dvs_q,   dvs_d;
    logic [XLEN-1:0] rem_q,   rem_d;
    logic [XLEN-1:0] quo_q,   quo_d;
    logic            qneg_q,  qneg_d;
    logic            rneg_q,  rneg_d;
    logic [XLEN-1:0] res_q,   res_d;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_signed = ~bus.op[OP_UNS_BIT];
    assign w_a_neg  = w_signed & bus.rs1_data[XLEN-1];
    assign w_b_neg  = w_signed & bus.rs2_data[XLEN-1];
    assign w_a_mag  = w_a_neg ? -bus.rs1_data : bus.rs1_data;
    assign w_b_mag  = w_b_neg ? -bus.rs2_data : bus.rs2_data;
    assign w_div0   = (bus.rs2_data == '0);
    assign w_ovf    = w_signed && (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);

    // Partial remainder is below the divisor, so bit XLEN of the trial is its sign.
    assign w_rem_sh = {rem_q, quo_q[XLEN-1]};
    assign w_trial  = w_rem_sh - {1'b0, dvs_q};

    assign w_quo_fix = qneg_q ? -quo_q : quo_q;
    assign w_rem_fix = rneg_q ? -rem_q : rem_q;

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = (state_q == S_DONE) && !bus.flush;
    assign bus.wb_enable    = bus.result_valid && (addr_q != 5'd0);
    assign bus.result       = res_q;
    assign bus.wb_addr      = addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d   = bus.op;
                    addr_d = bus.rd_addr;
                    if (w_div0) begin
                        res_d   = bus.op[OP_REM_BIT] ? bus.rs1_data : '1;
                        state_d = S_DONE;
                    end else if (w_ovf) begin
                        res_d   = bus.op[OP_REM_BIT] ? '0 : INT_MIN;
                        state_d = S_DONE;
                    end else begin
                        dvs_d   = w_b_mag;
                        rem_d   = '0;
                        quo_d   = w_a_mag;
                        qneg_d  = w_a_neg ^ w_b_neg;
                        rneg_d  = w_a_neg;
                        cnt_d   = 6'd0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], ~w_trial[XLEN]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = op_q[OP_REM_BIT] ? w_rem_fix : w_quo_fix;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'd0;
            addr_q  <= 5'd0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end
endmodule
`default_nettype wire
